// File: rtl/hack_pkg.sv
// Shared definitions for the multi-cycle Hack CPU control path.
// Includes widths, instruction field positions, FSM states and the decoded-field types.
package hack_pkg;

    localparam int HACK_W  = 16;
    localparam int HACK_AW = 15;

    localparam int BIT_IS_C = 15;
    localparam int BIT_A    = 12;
    localparam int BIT_ZX   = 11;
    localparam int BIT_NO   = 6;
    localparam int BIT_DA   = 5;
    localparam int BIT_DM   = 3;
    localparam int BIT_JLT  = 2;
    localparam int BIT_JGT  = 0;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        MREAD,
        EXEC,
        MWRITE
    } state_t;

    typedef struct packed {
        logic zx;
        logic nx;
        logic zy;
        logic ny;
        logic f;
        logic no;
    } alu_ctrl_t;

    typedef struct packed {
        logic a_reg;
        logic d_reg;
        logic m_mem;
    } dest_t;

    typedef struct packed {
        logic lt;
        logic eq;
        logic gt;
    } jump_t;

    function automatic logic jump_taken(jump_t j, logic zr, logic ng);
        return (j.lt & ng) | (j.eq & zr) | (j.gt & ~ng & ~zr);
    endfunction

endpackage

// File: rtl/alu.sv
// Hack ALU: combinational datapath driven by the six control bits.
// The flags zr and ng describe the result; they are used for jump resolution.
module alu
    import hack_pkg::*;
(
    input  logic [HACK_W-1:0] x,
    input  logic [HACK_W-1:0] y,
    input  logic              zx,
    input  logic              nx,
    input  logic              zy,
    input  logic              ny,
    input  logic              f,
    input  logic              no,
    output logic [HACK_W-1:0] out,
    output logic              zr,
    output logic              ng
);

    logic [HACK_W-1:0] x_z;
    logic [HACK_W-1:0] x_n;
    logic [HACK_W-1:0] y_z;
    logic [HACK_W-1:0] y_n;
    logic [HACK_W-1:0] f_out;

    always_comb begin
        x_z   = zx ? '0 : x;
        x_n   = nx ? ~x_z : x_z;
        y_z   = zy ? '0 : y;
        y_n   = ny ? ~y_z : y_z;
        f_out = f ? (x_n + y_n) : (x_n & y_n);
        out   = no ? ~f_out : f_out;
        zr    = (out == '0);
        ng    = out[HACK_W-1];
    end

endmodule

// File: rtl/hack_decoder.sv
// Splits an instruction word into the Hack instruction fields.
// It also produces the zero-extended A-instruction immediate.
module hack_decoder
    import hack_pkg::*;
(
    input  logic [HACK_W-1:0] ir,
    output logic              is_c,
    output logic              a_sel,
    output alu_ctrl_t         alu_ctrl,
    output dest_t             dest,
    output jump_t             jump,
    output logic [HACK_W-1:0] a_imm
);

    always_comb begin
        is_c     = ir[BIT_IS_C];
        a_sel    = ir[BIT_A];
        alu_ctrl = alu_ctrl_t'(ir[BIT_ZX:BIT_NO]);
        dest     = dest_t'(ir[BIT_DA:BIT_DM]);
        jump     = jump_t'(ir[BIT_JLT:BIT_JGT]);
        a_imm    = {1'b0, ir[HACK_AW-1:0]};
    end

endmodule

// File: rtl/hack_cpu_ctrl.sv
// Multi-cycle Hack CPU control: fetch, decode, optional memory read, execute, optional write.
// Register updates happen atomically on the single commit cycle flagged by retire.
module hack_cpu_ctrl
    import hack_pkg::*;
#(
    parameter logic [HACK_AW-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [HACK_AW-1:0] imem_addr,
    input  logic               imem_ack,
    input  logic [HACK_W-1:0]  imem_data,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic [HACK_AW-1:0] dmem_addr,
    output logic [HACK_W-1:0]  dmem_wdata,
    input  logic [HACK_W-1:0]  dmem_rdata,
    input  logic               dmem_ack,
    output logic [HACK_AW-1:0] pc,
    output logic               retire
);

    state_t state;
    state_t state_next;

    logic [HACK_W-1:0]  a_q;
    logic [HACK_W-1:0]  d_q;
    logic [HACK_W-1:0]  ir_q;
    logic [HACK_W-1:0]  m_q;
    logic [HACK_W-1:0]  r_q;
    logic [HACK_AW-1:0] pc_q;
    logic               jmp_q;

    logic               is_c;
    logic               a_sel;
    alu_ctrl_t          alu_ctrl;
    dest_t              dest;
    jump_t              jump;
    logic [HACK_W-1:0]  a_imm;

    logic [HACK_W-1:0]  alu_y;
    logic [HACK_W-1:0]  alu_out;
    logic               alu_zr;
    logic               alu_ng;
    logic               jmp_now;

    logic               commit;
    logic               take;
    logic [HACK_W-1:0]  result;

    hack_decoder u_dec (
        .ir       (ir_q),
        .is_c     (is_c),
        .a_sel    (a_sel),
        .alu_ctrl (alu_ctrl),
        .dest     (dest),
        .jump     (jump),
        .a_imm    (a_imm)
    );

    assign alu_y = a_sel ? m_q : a_q;

    alu u_alu (
        .x   (d_q),
        .y   (alu_y),
        .zx  (alu_ctrl.zx),
        .nx  (alu_ctrl.nx),
        .zy  (alu_ctrl.zy),
        .ny  (alu_ctrl.ny),
        .f   (alu_ctrl.f),
        .no  (alu_ctrl.no),
        .out (alu_out),
        .zr  (alu_zr),
        .ng  (alu_ng)
    );

    assign jmp_now = jump_taken(jump, alu_zr, alu_ng);

    // EXEC commits straight from the ALU; MWRITE commits from the latched result and jump.
    always_comb begin
        state_next = state;
        commit     = 1'b0;
        take       = 1'b0;
        result     = r_q;
        case (state)
            FETCH: begin
                if (imem_ack) state_next = DECODE;
            end
            DECODE: begin
                if (!is_c) begin
                    commit     = 1'b1;
                    state_next = FETCH;
                end else if (a_sel) begin
                    state_next = MREAD;
                end else begin
                    state_next = EXEC;
                end
            end
            MREAD: begin
                if (dmem_ack) state_next = EXEC;
            end
            EXEC: begin
                if (dest.m_mem) begin
                    state_next = MWRITE;
                end else begin
                    commit     = 1'b1;
                    take       = jmp_now;
                    result     = alu_out;
                    state_next = FETCH;
                end
            end
            MWRITE: begin
                if (dmem_ack) begin
                    commit     = 1'b1;
                    take       = jmp_q;
                    state_next = FETCH;
                end
            end
            default: state_next = FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FETCH;
            pc_q  <= RESET_PC;
            a_q   <= '0;
            d_q   <= '0;
            ir_q  <= '0;
            m_q   <= '0;
            r_q   <= '0;
            jmp_q <= 1'b0;
        end else begin
            state <= state_next;
            if (state == FETCH && imem_ack) ir_q <= imem_data;
            if (state == MREAD && dmem_ack) m_q <= dmem_rdata;
            if (state == EXEC) begin
                r_q   <= alu_out;
                jmp_q <= jmp_now;
            end
            if (commit) begin
                if (!is_c) begin
                    a_q <= a_imm;
                end else begin
                    if (dest.a_reg) a_q <= result;
                    if (dest.d_reg) d_q <= result;
                end
                // Jump target is A as it stood before this instruction's write.
                pc_q <= take ? a_q[HACK_AW-1:0] : pc_q + HACK_AW'(1);
            end
        end
    end

    // Strobes are gated by rst so they fall the moment reset is applied.
    always_comb begin
        imem_req   = (state == FETCH) && !rst;
        dmem_req   = (state == MREAD || state == MWRITE) && !rst;
        dmem_we    = (state == MWRITE) && !rst;
        retire     = commit && !rst;
        imem_addr  = pc_q;
        pc         = pc_q;
        dmem_addr  = a_q[HACK_AW-1:0];
        dmem_wdata = r_q;
    end

endmodule

// File: tb/tb_hack_cpu_ctrl.sv
// Scoreboard bench for hack_cpu_ctrl: an instruction-level Hack model predicts bus events,
// a monitor compares them against what the core presents on its ports.
module tb_hack_cpu_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [14:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [15:0] imem_data = '0;
    logic        dmem_req;
    logic        dmem_we;
    logic [14:0] dmem_addr;
    logic [15:0] dmem_wdata;
    logic [15:0] dmem_rdata = '0;
    logic        dmem_ack = 1'b0;
    logic [14:0] pc;
    logic        retire;

    hack_cpu_ctrl #(.RESET_PC(15'h0000)) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_data  (imem_data),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .dmem_ack   (dmem_ack),
        .pc         (pc),
        .retire     (retire)
    );

    always #5 clk = ~clk;

    localparam int EV_FETCH  = 0;
    localparam int EV_READ   = 1;
    localparam int EV_WRITE  = 2;
    localparam int EV_RETIRE = 3;

    typedef struct {
        int          kind;
        logic [14:0] addr;
        logic [15:0] data;
        int          base;
    } ev_t;

    ev_t q[$];
    ev_t ev;

    logic [15:0] rom  [32768];
    logic [15:0] ram  [32768];
    logic [15:0] mram [32768];

    int n_cmp = 0;
    int n_bad = 0;
    int imin = 0, imax = 0, dmin = 0, dmax = 0;
    int iwait = -1, dwait = -1;
    int cyc = 0, wt = 0;

    function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endfunction

    function automatic void push_ev(int kind, logic [14:0] addr, logic [15:0] data, int base);
        ev_t e;
        e.kind = kind;
        e.addr = addr;
        e.data = data;
        e.base = base;
        q.push_back(e);
    endfunction

    function automatic logic [15:0] alu_ref(logic [15:0] x, logic [15:0] y, logic [5:0] c);
        logic [15:0] o;
        if (c[5]) x = '0;
        if (c[4]) x = ~x;
        if (c[3]) y = '0;
        if (c[2]) y = ~y;
        o = c[1] ? x + y : x & y;
        if (c[0]) o = ~o;
        return o;
    endfunction

    // Instruction-level Hack interpreter producing the expected bus/retire sequence.
    task automatic model_run(input int n);
        logic [15:0] ra, rd, ins, y, o;
        logic [14:0] rpc;
        logic        take;
        ra  = '0;
        rd  = '0;
        rpc = '0;
        for (int k = 0; k < n; k++) begin
            ins = rom[rpc];
            push_ev(EV_FETCH, rpc, '0, 0);
            if (!ins[15]) begin
                ra = {1'b0, ins[14:0]};
                push_ev(EV_RETIRE, '0, '0, 2);
                rpc = rpc + 15'd1;
            end else begin
                y = ins[12] ? mram[ra[14:0]] : ra;
                if (ins[12]) push_ev(EV_READ, ra[14:0], '0, 0);
                o = alu_ref(rd, y, ins[11:6]);
                take = (ins[2] && o[15]) || (ins[1] && o == 16'd0) ||
                       (ins[0] && !o[15] && o != 16'd0);
                if (ins[3]) begin
                    mram[ra[14:0]] = o;
                    push_ev(EV_WRITE, ra[14:0], o, 0);
                end
                push_ev(EV_RETIRE, '0, '0, 3 + int'(ins[12]) + int'(ins[3]));
                rpc = take ? ra[14:0] : rpc + 15'd1;
                if (ins[5]) ra = o;
                if (ins[4]) rd = o;
            end
        end
    endtask

    // Memory responders with configurable wait states.
    always @(posedge clk) begin
        #1;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        if (rst) begin
            iwait = -1;
            dwait = -1;
        end else begin
            if (imem_req) begin
                if (iwait < 0) iwait = $urandom_range(imax, imin);
                if (iwait == 0) begin
                    imem_ack  = 1'b1;
                    imem_data = rom[imem_addr];
                    iwait     = -1;
                end else begin
                    iwait--;
                end
            end
            if (dmem_req) begin
                if (dwait < 0) dwait = $urandom_range(dmax, dmin);
                if (dwait == 0) begin
                    dmem_ack = 1'b1;
                    if (dmem_we) ram[dmem_addr] = dmem_wdata;
                    else dmem_rdata = ram[dmem_addr];
                    dwait = -1;
                end else begin
                    dwait--;
                end
            end
        end
    end

    // Monitor: pops the scoreboard whenever the core completes a transfer or retires.
    always @(negedge clk) begin
        if (rst) begin
            cyc = 0;
            wt  = 0;
        end else begin
            cyc++;
            if ((imem_req && !imem_ack) || (dmem_req && !dmem_ack)) wt++;
            if (imem_req && dmem_req) chk("one_port_at_a_time", 1, 0);
            if (imem_req && imem_ack && q.size() > 0) begin
                ev = q.pop_front();
                chk("fetch_kind", EV_FETCH, ev.kind);
                chk("fetch_addr", imem_addr, ev.addr);
                chk("fetch_pc", pc, ev.addr);
            end
            if (dmem_req && dmem_ack && q.size() > 0) begin
                ev = q.pop_front();
                chk("dmem_kind", dmem_we ? EV_WRITE : EV_READ, ev.kind);
                chk("dmem_addr", dmem_addr, ev.addr);
                if (dmem_we) chk("dmem_wdata", dmem_wdata, ev.data);
            end
            if (retire && q.size() > 0) begin
                ev = q.pop_front();
                chk("retire_kind", EV_RETIRE, ev.kind);
                chk("instr_cycles", cyc - wt, ev.base);
                cyc = 0;
                wt  = 0;
            end
        end
    end

    task automatic hold_reset();
        rst = 1'b1;
        #1;
        chk("rst_imem_req", imem_req, 0);
        chk("rst_dmem_req", dmem_req, 0);
        chk("rst_dmem_we", dmem_we, 0);
        chk("rst_retire", retire, 0);
        chk("rst_pc", pc, 0);
        repeat (2) @(posedge clk);
    endtask

    task automatic release_reset();
        @(posedge clk);
        #2 rst = 1'b0;
    endtask

    task automatic clear_mem(input bit random_rom);
        for (int i = 0; i < 32768; i++) begin
            rom[i]  = random_rom ? 16'($urandom) : 16'h0000;
            ram[i]  = 16'($urandom);
            mram[i] = ram[i];
        end
    endtask

    task automatic drain(input int budget, input string name);
        int c;
        c = 0;
        while (q.size() > 0 && c < budget) begin
            @(posedge clk);
            c++;
        end
        chk({name, "_events_left"}, q.size(), 0);
        q.delete();
    endtask

    initial begin
        // @5; D=A; M=D
        hold_reset();
        clear_mem(0);
        rom[0] = 16'h0005; rom[1] = 16'hEC10; rom[2] = 16'hE308;
        model_run(3);
        release_reset();
        drain(200, "load_d");

        // @5; D=A; @100; M=D+1
        hold_reset();
        clear_mem(0);
        rom[0] = 16'h0005; rom[1] = 16'hEC10; rom[2] = 16'h0064; rom[3] = 16'hE7C8;
        model_run(4);
        release_reset();
        drain(200, "write_only");

        // @3; D=M (mem[3]=0x1234); @50; M=D
        hold_reset();
        clear_mem(0);
        ram[3] = 16'h1234; mram[3] = 16'h1234;
        rom[0] = 16'h0003; rom[1] = 16'hFC10; rom[2] = 16'h0032; rom[3] = 16'hE308;
        model_run(4);
        release_reset();
        drain(200, "read_only");

        // JEQ taken/not taken, JMP to 0x7FFF, PC wrap to 0
        hold_reset();
        clear_mem(0);
        rom[0] = 16'h0007; rom[1] = 16'hEA90; rom[2] = 16'hE302;
        rom[7] = 16'hEFD0; rom[8] = 16'hE302; rom[9] = 16'h7FFF; rom[10] = 16'hEA87;
        rom[32767] = 16'h0000;
        model_run(9);
        release_reset();
        drain(300, "jumps");

        // @100; M=M+1 with 3 wait states, reset during MWRITE
        hold_reset();
        clear_mem(0);
        dmin = 3; dmax = 3;
        rom[0] = 16'h0064; rom[1] = 16'hFDC8;
        model_run(2);
        release_reset();
        begin
            bit seen;
            seen = 0;
            for (int c = 0; c < 200 && !seen; c++) begin
                @(negedge clk);
                if (dmem_req && dmem_we) seen = 1;
            end
            chk("mwrite_reached", seen, 1);
        end
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_dmem_req", dmem_req, 0);
        chk("midrst_imem_req", imem_req, 0);
        chk("midrst_retire", retire, 0);
        chk("midrst_pc", pc, 0);
        chk("midrst_uncommitted", q.size(), 2);
        q.delete();
        clear_mem(0);
        dmin = 0; dmax = 0;
        rom[0] = 16'hE308;
        model_run(2);
        repeat (2) @(posedge clk);
        release_reset();
        drain(200, "after_reset");

        // Random programs with random wait states
        imin = 0; imax = 2; dmin = 0; dmax = 2;
        for (int t = 0; t < 3; t++) begin
            hold_reset();
            clear_mem(1);
            model_run(250);
            release_reset();
            drain(6000, "random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
